// File: rtl/alu_rmw_sequencer.sv
// Read-modify-write sequencer for the 6502 shift/rotate group (ASL/LSR/ROL/ROR).
// Drives the registered ALU from latched operands and moves the operand over the memory bus.
module alu_rmw_sequencer #(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [3:0]        op_in,
  input  logic              mem_mode,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [7:0]        acc_in,
  input  logic [6:0]        status_in,
  input  logic              mem_ready,
  input  logic [7:0]        mem_rdata,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic [3:0]        alu_op,
  output logic [7:0]        alu_a,
  output logic [6:0]        alu_flags,
  input  logic [7:0]        alu_result,
  input  logic [6:0]        alu_flags_res,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [7:0]        result,
  output logic [6:0]        status_out,
  output logic              status_we,
  output logic              acc_we
);

  // Opcode encodings and status bit positions shared with the alu instance.
  localparam logic [3:0] OP_ASL = 4'h5;
  localparam logic [3:0] OP_LSR = 4'h6;
  localparam logic [3:0] OP_ROL = 4'h7;
  localparam logic [3:0] OP_ROR = 4'h8;

  localparam int CARRY_FLAG    = 0;
  localparam int ZERO_FLAG     = 1;
  localparam int NEGATIVE_FLAG = 6;

  localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE, READ, DUMMY, EXEC, CAPT, WRITE, DONE
  } state_e;

  state_e              state_q;
  logic [3:0]          op_q;
  logic                mem_mode_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [6:0]          status_q;
  logic [7:0]          operand_q;
  logic [7:0]          result_q;
  logic [6:0]          status_out_q;
  logic [WD_W-1:0]     wd_q;
  logic                mem_re_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [7:0]          mem_wdata_q;
  logic                busy_q;
  logic                done_q;
  logic                err_q;
  logic                status_we_q;
  logic                acc_we_q;

  logic                op_valid;
  logic                bus_state;
  logic                wd_expired;
  logic                wd_abort;
  logic [6:0]          status_merge;

  assign op_valid   = (op_in == OP_ASL) || (op_in == OP_LSR) ||
                      (op_in == OP_ROL) || (op_in == OP_ROR);
  assign bus_state  = (state_q == READ) || (state_q == DUMMY) || (state_q == WRITE);
  assign wd_expired = (TIMEOUT != 0) && (wd_q == WD_W'(TIMEOUT - 1));
  assign wd_abort   = bus_state && !mem_ready && wd_expired;

  // Only C, Z and N come from the shifter; every other bit keeps its value from start.
  always_comb begin
    status_merge                = status_q;
    status_merge[CARRY_FLAG]    = alu_flags_res[CARRY_FLAG];
    status_merge[ZERO_FLAG]     = alu_flags_res[ZERO_FLAG];
    status_merge[NEGATIVE_FLAG] = alu_flags_res[NEGATIVE_FLAG];
  end

  // NOTE: all state uses non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      op_q         <= '0;
      mem_mode_q   <= 1'b0;
      addr_q       <= '0;
      status_q     <= '0;
      operand_q    <= '0;
      result_q     <= '0;
      status_out_q <= '0;
      wd_q         <= '0;
      mem_re_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      status_we_q  <= 1'b0;
      acc_we_q     <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      status_we_q <= 1'b0;
      acc_we_q    <= 1'b0;
      if (wd_abort) begin
        state_q  <= DONE;
        mem_re_q <= 1'b0;
        mem_we_q <= 1'b0;
        done_q   <= 1'b1;
        err_q    <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              op_q       <= op_in;
              mem_mode_q <= mem_mode;
              addr_q     <= addr_in;
              status_q   <= status_in;
              busy_q     <= 1'b1;
              err_q      <= 1'b0;
              if (!op_valid) begin
                state_q <= DONE;
                done_q  <= 1'b1;
                err_q   <= 1'b1;
              end else if (mem_mode) begin
                state_q    <= READ;
                mem_re_q   <= 1'b1;
                mem_addr_q <= addr_in;
                wd_q       <= '0;
              end else begin
                operand_q <= acc_in;
                state_q   <= EXEC;
              end
            end
          end
          READ: begin
            if (mem_ready) begin
              operand_q   <= mem_rdata;
              mem_re_q    <= 1'b0;
              mem_we_q    <= 1'b1;
              mem_wdata_q <= mem_rdata;
              wd_q        <= '0;
              state_q     <= DUMMY;
            end else begin
              wd_q <= wd_q + 1'b1;
            end
          end
          DUMMY: begin
            if (mem_ready) begin
              mem_we_q <= 1'b0;
              state_q  <= CAPT;
            end else begin
              wd_q <= wd_q + 1'b1;
            end
          end
          EXEC: state_q <= CAPT;
          CAPT: begin
            result_q     <= alu_result;
            status_out_q <= status_merge;
            if (mem_mode_q) begin
              state_q     <= WRITE;
              mem_we_q    <= 1'b1;
              mem_addr_q  <= addr_q;
              mem_wdata_q <= alu_result;
              wd_q        <= '0;
            end else begin
              state_q     <= DONE;
              done_q      <= 1'b1;
              status_we_q <= 1'b1;
              acc_we_q    <= 1'b1;
            end
          end
          WRITE: begin
            if (mem_ready) begin
              mem_we_q    <= 1'b0;
              state_q     <= DONE;
              done_q      <= 1'b1;
              status_we_q <= 1'b1;
            end else begin
              wd_q <= wd_q + 1'b1;
            end
          end
          DONE: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // ALU inputs come straight from latched registers so stalls cannot disturb them.
  assign alu_op     = op_q;
  assign alu_a      = operand_q;
  assign alu_flags  = status_q;
  assign mem_re     = mem_re_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign result     = result_q;
  assign status_out = status_out_q;
  assign status_we  = status_we_q;
  assign acc_we     = acc_we_q;

endmodule

// File: tb/tb_alu_rmw_sequencer.sv
// Directed bench for alu_rmw_sequencer: a behavioural shifter ALU, a bus logger and
// hand-computed expectations for latency, bus traffic, result and merged flags.
module tb_alu_rmw_sequencer;

  localparam logic [3:0] OP_ASL = 4'h5;
  localparam logic [3:0] OP_LSR = 4'h6;
  localparam logic [3:0] OP_ROL = 4'h7;
  localparam logic [3:0] OP_ROR = 4'h8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  op_in;
  logic        mem_mode;
  logic [15:0] addr_in;
  logic [7:0]  acc_in;
  logic [6:0]  status_in;
  logic        mem_ready;
  logic [7:0]  mem_rdata;
  logic        mem_re;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [3:0]  alu_op;
  logic [7:0]  alu_a;
  logic [6:0]  alu_flags;
  logic [7:0]  alu_result;
  logic [6:0]  alu_flags_res;
  logic        busy;
  logic        done;
  logic        err;
  logic [7:0]  result;
  logic [6:0]  status_out;
  logic        status_we;
  logic        acc_we;

  int n_cmp = 0;
  int n_err = 0;
  int overlap_cnt = 0;
  int alu_chg = 0;
  logic [24:0] bus_log[$];

  alu_rmw_sequencer #(.ADDR_W(16), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_in(op_in), .mem_mode(mem_mode),
    .addr_in(addr_in), .acc_in(acc_in), .status_in(status_in),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_re(mem_re), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .alu_op(alu_op), .alu_a(alu_a),
    .alu_flags(alu_flags), .alu_result(alu_result), .alu_flags_res(alu_flags_res),
    .busy(busy), .done(done), .err(err), .result(result), .status_out(status_out),
    .status_we(status_we), .acc_we(acc_we)
  );

  always #5 clk = ~clk;

  // Registered shifter stand-in; non-CZN flag bits are inverted so a bad merge shows up.
  always @(posedge clk) begin : alu_model
    logic [7:0] r;
    logic       c;
    case (alu_op)
      OP_ASL:  begin r = {alu_a[6:0], 1'b0};         c = alu_a[7]; end
      OP_LSR:  begin r = {1'b0, alu_a[7:1]};         c = alu_a[0]; end
      OP_ROL:  begin r = {alu_a[6:0], alu_flags[0]}; c = alu_a[7]; end
      OP_ROR:  begin r = {alu_flags[0], alu_a[7:1]}; c = alu_a[0]; end
      default: begin r = alu_a;                      c = alu_flags[0]; end
    endcase
    alu_result    <= r;
    alu_flags_res <= {r[7], ~alu_flags[5:2], (r == 8'h00), c};
  end

  // Logs completed bus transfers and watches ALU inputs once the dummy write starts.
  logic        armed = 1'b0;
  logic [18:0] alu_ref;
  always @(negedge clk) begin
    if ((mem_re || mem_we) && mem_ready)
      bus_log.push_back({mem_we, mem_addr, mem_re ? mem_rdata : mem_wdata});
    if (mem_re && mem_we) overlap_cnt++;
    if (!busy) armed = 1'b0;
    else if (!armed) begin
      if (mem_we) begin
        armed   = 1'b1;
        alu_ref = {alu_op, alu_a, alu_flags};
      end
    end else if ({alu_op, alu_a, alu_flags} != alu_ref) alu_chg++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [3:0] op, input logic mode, input logic [15:0] addr,
                          input logic [7:0] acc, input logic [6:0] st);
    op_in = op; mem_mode = mode; addr_in = addr; acc_in = acc; status_in = st;
    start = 1'b1;
    bus_log.delete();
    tick();
    start = 1'b0;
  endtask

  // mode 0: ready tied high, 1: three wait cycles per bus access, 2: ready stuck low
  task automatic wait_done(input int mode, output int lat);
    int sc = 0;
    lat = 0;
    while (!done && lat < 40) begin
      case (mode)
        0: mem_ready = 1'b1;
        1: begin
          if (mem_re || mem_we) begin
            if (sc < 3) begin mem_ready = 1'b0; sc++; end
            else begin mem_ready = 1'b1; sc = 0; end
          end else mem_ready = 1'b0;
        end
        default: mem_ready = 1'b0;
      endcase
      tick();
      lat++;
    end
    check("done_seen", {31'd0, done}, 32'd1);
  endtask

  task automatic check_log(input string tag, input int idx, input logic we,
                           input logic [15:0] addr, input logic [7:0] data);
    logic [24:0] got;
    got = (idx < bus_log.size()) ? bus_log[idx] : '1;
    check(tag, {7'd0, got}, {7'd0, we, addr, data});
  endtask

  initial begin
    int lat;
    rst_n = 1'b0; start = 1'b0; op_in = '0; mem_mode = 1'b0; addr_in = '0;
    acc_in = '0; status_in = '0; mem_ready = 1'b0; mem_rdata = '0;
    #3;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_strobes", {26'd0, mem_re, mem_we, done, err, status_we, acc_we}, 32'd0);
    check("rst_result", {17'd0, result, status_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // ACC ASL 0x81, I set: result 0x02, C=1 -> status 0x05
    start_op(OP_ASL, 1'b0, 16'h0000, 8'h81, 7'h04);
    check("acc_busy", {31'd0, busy}, 32'd1);
    wait_done(0, lat);
    check("acc_lat", lat, 2);
    check("acc_result", {24'd0, result}, 32'h02);
    check("acc_status", {25'd0, status_out}, 32'h05);
    check("acc_we_flags", {29'd0, err, status_we, acc_we}, 32'b011);
    check("acc_nobus", bus_log.size(), 0);
    tick();
    check("acc_idle", {31'd0, busy}, 32'd0);

    // Watchdog: ready stuck low in READ; previous result/status must survive
    start_op(OP_ASL, 1'b1, 16'h0040, 8'h00, 7'h7F);
    wait_done(2, lat);
    check("wd_lat", lat, 4);
    check("wd_flags", {28'd0, err, status_we, acc_we, mem_re}, 32'b1000);
    check("wd_result", {17'd0, result, status_out}, {17'd0, 8'h02, 7'h05});
    check("wd_nobus", bus_log.size(), 0);
    tick();

    // MEM ROL 0x80 at 0x0010, C=0: result 0x00, C=1 Z=1
    mem_rdata = 8'h80;
    start_op(OP_ROL, 1'b1, 16'h0010, 8'h00, 7'h00);
    wait_done(0, lat);
    check("rol_lat", lat, 4);
    check("rol_result", {24'd0, result}, 32'h00);
    check("rol_status", {25'd0, status_out}, 32'h03);
    check("rol_we_flags", {29'd0, err, status_we, acc_we}, 32'b010);
    check("rol_log_n", bus_log.size(), 3);
    check_log("rol_read", 0, 1'b0, 16'h0010, 8'h80);
    check_log("rol_dummy", 1, 1'b1, 16'h0010, 8'h80);
    check_log("rol_write", 2, 1'b1, 16'h0010, 8'h00);
    tick();

    // MEM LSR 0x01 with three wait cycles per access: 9 extra cycles
    mem_rdata = 8'h01;
    alu_chg = 0;
    start_op(OP_LSR, 1'b1, 16'h1234, 8'h00, 7'h20);
    wait_done(1, lat);
    check("lsr_lat", lat, 13);
    check("lsr_result", {24'd0, result}, 32'h00);
    check("lsr_status", {25'd0, status_out}, 32'h23);
    check("lsr_log_n", bus_log.size(), 3);
    check_log("lsr_read", 0, 1'b0, 16'h1234, 8'h01);
    check_log("lsr_dummy", 1, 1'b1, 16'h1234, 8'h01);
    check_log("lsr_write", 2, 1'b1, 16'h1234, 8'h00);
    check("lsr_alu_stable", alu_chg, 0);
    tick();

    // Invalid opcode: immediate done with err, no bus traffic
    start_op(4'hF, 1'b1, 16'h0050, 8'h00, 7'h00);
    wait_done(0, lat);
    check("inv_lat", lat, 0);
    check("inv_flags", {28'd0, err, status_we, acc_we, mem_re}, 32'b1000);
    tick();
    check("inv_nobus", bus_log.size(), 0);

    // Start while busy is ignored
    start_op(OP_ASL, 1'b0, 16'h0000, 8'h40, 7'h00);
    op_in = OP_LSR; mem_mode = 1'b1; acc_in = 8'hFF; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(0, lat);
    check("ign_lat", lat, 1);
    check("ign_result", {17'd0, result, status_out}, {17'd0, 8'h80, 7'h40});
    tick();
    tick();
    check("ign_idle", {30'd0, busy, mem_re}, 32'd0);
    check("ign_nobus", bus_log.size(), 0);

    // Reset in the middle of WRITE
    mem_rdata = 8'h11; mem_ready = 1'b1;
    start_op(OP_ASL, 1'b1, 16'h0020, 8'h00, 7'h00);
    tick();
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    tick();
    check("rst_in_write", {23'd0, mem_we, mem_wdata}, {23'd0, 1'b1, 8'h22});
    #2 rst_n = 1'b0;
    #1;
    check("rst_we_drop", {30'd0, mem_we, busy}, 32'd0);
    check("rst_outputs", {17'd0, result, status_out}, 32'd0);
    check("rst_bus", {8'd0, mem_addr, mem_wdata}, 32'd0);
    check("rst_alu", {13'd0, alu_op, alu_a, alu_flags}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // ACC ROR 0x01 with C=1: result 0x80, C=1 N=1
    start_op(OP_ROR, 1'b0, 16'h0000, 8'h01, 7'h01);
    wait_done(0, lat);
    check("ror_lat", lat, 2);
    check("ror_result", {24'd0, result}, 32'h80);
    check("ror_status", {25'd0, status_out}, 32'h41);
    check("ror_we_flags", {29'd0, err, status_we, acc_we}, 32'b011);
    tick();
    check("no_overlap", overlap_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_rmw_sequencer.md
Name: alu_rmw_sequencer

Overview:
- Sequences the registered shift/rotate ALU for 6502 read-modify-write instructions: ASL/LSR/ROL/ROR on the accumulator or on memory.
- Fetches the operand, performs the 6502 dummy write of the original value, waits out the ALU's 1-cycle registered latency, writes the result back, and hands merged status flags to the register file.
- Sits between the instruction decoder (start/op/addr), the memory bus and the alu instance.

Parameters:
ADDR_W, 16, memory address width.
TIMEOUT, 15, max cycles to wait for mem_ready in any bus state; 0 disables the watchdog.

Ports:
clk  input  1  system clock, all state on rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request pulse, sampled in IDLE only.
op_in  input  4  ALU opcode per alu_ops.vh; ASL, LSR, ROL, ROR are valid.
mem_mode  input  1  1 = memory operand at addr_in, 0 = accumulator.
addr_in  input  ADDR_W  operand address.
acc_in  input  8  accumulator value.
status_in  input  7  current status register.
mem_ready  input  1  bus completes current access this cycle.
mem_rdata  input  8  read data, valid when mem_ready=1 in READ.
mem_re  output  1  read strobe.
mem_we  output  1  write strobe.
mem_addr  output  ADDR_W  bus address.
mem_wdata  output  8  write data.
alu_op  output  4  to alu.alu_op.
alu_a  output  8  to alu.inputA.
alu_flags  output  7  to alu.status_flags_in.
alu_result  input  8  alu.ALU_output.
alu_flags_res  input  7  alu.ALU_flags_output.
busy  output  1  high in every state except IDLE.
done  output  1  1-cycle completion pulse.
err  output  1  valid with done: invalid op or watchdog timeout.
result  output  8  final operand value, held until next done.
status_out  output  7  status_in latched at start with C, Z, N replaced by ALU flags.
status_we  output  1  equals done & ~err.
acc_we  output  1  done & ~err & ~mem_mode_q.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All strobes (mem_re, mem_we, done, err, status_we, acc_we) deassert immediately. result, status_out, alu_op, alu_a, alu_flags and mem_* buses go to 0.
- States: IDLE, READ, DUMMY, EXEC, CAPT, WRITE, DONE.
- IDLE:
  - start=1 latches op_in, mem_mode, addr_in and status_in.
  - Invalid op -> DONE with err=1 and no bus activity.
  - mem_mode=1 -> READ.
  - mem_mode=0 -> operand=acc_in, then EXEC.
- start while busy is ignored and not queued.
- READ: mem_re=1, mem_addr=addr_q. On mem_ready: operand<=mem_rdata, go to DUMMY.
- DUMMY: mem_we=1, mem_wdata=operand (original value). Waits for mem_ready, then CAPT.
- EXEC (accumulator path only): 1 cycle, then CAPT.
- alu_op, alu_a=operand and alu_flags=status_q are driven from latched registers and held constant from the operand latch until IDLE. This makes the ALU's re-sampling during DUMMY stalls harmless.
- CAPT: 1 cycle. Captures alu_result into result and builds status_out from status_q with bits `CARRY_FLAG, `ZERO_FLAG, `NEGATIVE_FLAG taken from alu_flags_res. Other bits are untouched. Then WRITE if mem_mode_q, else DONE.
- WRITE: mem_we=1, mem_addr=addr_q, mem_wdata=result. Waits for mem_ready, then DONE.
- DONE: done=1 for 1 cycle, then IDLE. busy drops in the following cycle, so a new start is accepted on the edge after DONE.
- Watchdog: a counter resets on entry to READ, DUMMY or WRITE. If TIMEOUT cycles elapse without mem_ready (TIMEOUT≠0), go to DONE with err=1, mem_re/mem_we drop, and result and status_out are unchanged.
- Latency, with cycle n following the start edge and mem_ready tied 1:
  - Accumulator: EXEC n, CAPT n+1, done at n+2.
  - Memory: READ n, DUMMY n+1, CAPT n+2, WRITE n+3, done at n+4.
- mem_re and mem_we are never high together. Both are 0 outside READ/DUMMY/WRITE.

Test Plan:
- ACC ASL, acc_in=0x81, status C=0 -> done at n+2, result=0x02, C=1 Z=0 N=0, acc_we=1, no mem strobes.
- MEM ROL, addr 0x0010, rdata 0x80, C=0, ready tied 1 -> read 0x0010, dummy write 0x80, write 0x00, done at n+4, C=1 Z=1 N=0, acc_we=0.
- MEM LSR, rdata 0x01, mem_ready low 3 cycles in each bus state -> correct sequence stretched by 9 cycles, result 0x00, Z=1 C=1, alu inputs stable throughout.
- TIMEOUT=4, mem_ready stuck 0 in READ -> done with err=1 after 4 cycles, status_we=0, result unchanged.
- op_in invalid (e.g. 0xF) -> done at n with err=1, no bus access; start pulses during a busy op -> ignored.
- rst_n low during WRITE -> mem_we drops same instant, busy=0, outputs zero; a subsequent ACC ROR of 0x01 with C=1 completes normally.
